// File: rtl/mix_shift_reg.sv
// Sequential register-mix stage: loads a 2N+1-bit working register from Q with
// the MUL/DIV/SQRT pattern, then steps it once per enabled cycle until done.
module mix_shift_reg #(
    parameter int N = 4,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [N-1:0]  Q,
    input  logic          step_en,
    input  logic          acc_we,
    input  logic [N:0]    acc_in,
    input  logic          q_bit,
    output logic [2*N:0]  mix_reg,
    output logic [CW-1:0] step_cnt,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    state_dbg
);

    // Handshake: start is sampled only in IDLE; step_en is honoured only in
    // RUN; done and err are single-cycle pulses with no acknowledge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_SQRT = 2'b10;
    localparam logic [1:0] OP_BAD  = 2'b11;

    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] STEPS_FULL = CW'(N);
    localparam logic [CW-1:0] STEPS_HALF = CW'(N / 2);

    state_t         state;
    state_t         state_next;
    logic [1:0]     op_q;
    logic [N-1:0]   q_q;
    logic [2*N:0]   load_val;
    logic [2*N:0]   t_val;
    logic [2*N:0]   shifted;
    logic [CW-1:0]  steps;
    logic [CW-1:0]  cnt_inc;
    logic           last_step;

    assign busy      = (state == LOAD) || (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;

    assign steps     = (op_q == OP_SQRT) ? STEPS_HALF : STEPS_FULL;
    assign cnt_inc   = step_cnt + CNT_ONE;
    assign last_step = (cnt_inc == steps);

    always_comb begin
        load_val = '0;
        if (op_q == OP_MUL) begin
            load_val = {{N{1'b0}}, q_q, 1'b0};
        end else begin
            load_val = {{(N + 1){1'b0}}, q_q};
        end
    end

    // The MUL upper field is one bit narrower, so acc_in[N] is dropped there.
    always_comb begin
        t_val = mix_reg;
        if (acc_we) begin
            if (op_q == OP_MUL) begin
                t_val[2*N:N+1] = acc_in[N-1:0];
            end else begin
                t_val[2*N:N] = acc_in;
            end
        end
    end

    always_comb begin
        shifted = t_val;
        case (op_q)
            OP_MUL:  shifted = {t_val[2*N], t_val[2*N:1]};
            OP_DIV:  shifted = {t_val[2*N-1:0], q_bit};
            OP_SQRT: shifted = {t_val[2*N-2:0], 1'b0, q_bit};
            default: shifted = t_val;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && (op != OP_BAD)) state_next = LOAD;
            LOAD: state_next = RUN;
            RUN:  if (step_en && last_step) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clr) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mix_reg  <= '0;
            step_cnt <= '0;
            op_q     <= OP_MUL;
            q_q      <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (clr) begin
                mix_reg  <= '0;
                step_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (op == OP_BAD) begin
                                err <= 1'b1;
                            end else begin
                                op_q <= op;
                                q_q  <= Q;
                            end
                        end
                    end
                    LOAD: begin
                        mix_reg  <= load_val;
                        step_cnt <= '0;
                    end
                    RUN: begin
                        if (step_en) begin
                            mix_reg  <= shifted;
                            step_cnt <= cnt_inc;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mix_shift_reg.sv
// Bench for mix_shift_reg (N=4): vector table of whole operations plus
// hand-written sequences for err, step_en gaps, clr, reset and busy start.
module tb_mix_shift_reg;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       start;
    logic [1:0] op;
    logic [3:0] q;
    logic       step_en;
    logic       acc_we;
    logic [4:0] acc_in;
    logic       q_bit;
    logic [8:0] mix_reg;
    logic [2:0] step_cnt;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] model_mix;
    logic [1:0] cur_op;

    typedef struct {
        logic [1:0] op;
        logic [3:0] q;
        logic       we;
        logic [4:0] acc;
        logic       qb;
        logic [8:0] exp_load;
        logic [8:0] exp_final;
        int         steps;
    } vec_t;

    vec_t vecs[7];

    mix_shift_reg #(.N(N)) dut (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .op(op), .Q(q),
        .step_en(step_en), .acc_we(acc_we), .acc_in(acc_in), .q_bit(q_bit),
        .mix_reg(mix_reg), .step_cnt(step_cnt), .busy(busy), .done(done),
        .err(err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] step_model(input logic [1:0] o, input logic [8:0] m,
                                              input logic we, input logic [4:0] acc,
                                              input logic qb);
        logic [8:0] t;
        t = m;
        if (we) begin
            if (o == 2'b00) t[8:5] = acc[3:0];
            else t[8:4] = acc;
        end
        case (o)
            2'b00:   return {t[8], t[8:1]};
            2'b01:   return {t[7:0], qb};
            default: return {t[6:0], 1'b0, qb};
        endcase
    endfunction

    task automatic start_op(input logic [1:0] o, input logic [3:0] qv, input logic [8:0] exp_load);
        start = 1'b1;
        op    = o;
        q     = qv;
        tick();
        start = 1'b0;
        check("load_busy", 32'(busy), 32'd1);
        tick();
        check("load_mix", 32'(mix_reg), 32'(exp_load));
        check("load_cnt", 32'(step_cnt), 32'd0);
        cur_op    = o;
        model_mix = exp_load;
    endtask

    task automatic do_step(input logic en, input logic we, input logic [4:0] acc, input logic qb);
        logic [8:0] e;
        step_en = en;
        acc_we  = we;
        acc_in  = acc;
        q_bit   = qb;
        if (en) begin
            model_mix = step_model(cur_op, model_mix, we, acc, qb);
            exp_q.push_back(model_mix);
        end
        tick();
        step_en = 1'b0;
        acc_we  = 1'b0;
        start   = 1'b0;
        if (en) begin
            e = exp_q.pop_front();
            check("step_mix", 32'(mix_reg), 32'(e));
        end else begin
            check("hold_mix", 32'(mix_reg), 32'(model_mix));
        end
    endtask

    initial begin
        vecs[0] = '{2'b00, 4'b0011, 1'b0, 5'b00000, 1'b0, 9'b000000110, 9'b000000000, 4};
        vecs[1] = '{2'b00, 4'b1000, 1'b0, 5'b00000, 1'b0, 9'b000010000, 9'b000000001, 4};
        vecs[2] = '{2'b00, 4'b0101, 1'b1, 5'b11000, 1'b0, 9'b000001010, 9'b110000000, 4};
        vecs[3] = '{2'b01, 4'b1011, 1'b0, 5'b00000, 1'b1, 9'b000001011, 9'b010111111, 4};
        vecs[4] = '{2'b01, 4'b0001, 1'b1, 5'b10101, 1'b0, 9'b000000001, 9'b010110000, 4};
        vecs[5] = '{2'b10, 4'b1001, 1'b0, 5'b00000, 1'b1, 9'b000001001, 9'b010010101, 2};
        vecs[6] = '{2'b10, 4'b1111, 1'b1, 5'b00011, 1'b0, 9'b000001111, 9'b011110000, 2};

        rst = 1'b0; clr = 1'b0; start = 1'b0; op = 2'b00; q = 4'b0;
        step_en = 1'b0; acc_we = 1'b0; acc_in = 5'b0; q_bit = 1'b0;
        #12;
        check("rst_mix", 32'(mix_reg), 32'd0);
        check("rst_cnt", 32'(step_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            start_op(vecs[v].op, vecs[v].q, vecs[v].exp_load);
            for (int s = 0; s < vecs[v].steps; s++) begin
                check("pre_done", 32'(done), 32'd0);
                do_step(1'b1, vecs[v].we, vecs[v].acc, vecs[v].qb);
                check("step_cnt", 32'(step_cnt), 32'(s + 1));
            end
            check("final_mix", 32'(mix_reg), 32'(vecs[v].exp_final));
            check("done_pulse", 32'(done), 32'd1);
            check("done_busy", 32'(busy), 32'd0);
            start = 1'b1;
            op    = 2'b01;
            q     = 4'b0110;
            tick();
            start = 1'b0;
            check("done_low", 32'(done), 32'd0);
            check("done_start_ign", 32'(busy), 32'd0);
            tick();
            check("hold_mix_idle", 32'(mix_reg), 32'(vecs[v].exp_final));
            check("hold_cnt_idle", 32'(step_cnt), 32'(vecs[v].steps));
        end

        // illegal op: err pulse only, nothing else moves
        start = 1'b1; op = 2'b11; q = 4'b1111;
        tick();
        start = 1'b0;
        check("err_pulse", 32'(err), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        check("err_mix", 32'(mix_reg), 32'(vecs[6].exp_final));
        tick();
        check("err_low", 32'(err), 32'd0);
        check("err_idle", 32'(state_dbg), 32'd0);

        // step_en gaps, with acc_we asserted on disabled cycles
        begin
            logic en_pat[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
            int ones = 0;
            start_op(2'b00, 4'b0011, 9'b000000110);
            for (int i = 0; i < 8; i++) begin
                check("gap_no_done", 32'(done), 32'd0);
                do_step(en_pat[i], ~en_pat[i], 5'b11111, 1'b1);
                if (en_pat[i]) ones++;
                check("gap_cnt", 32'(step_cnt), 32'(ones));
            end
            check("gap_final", 32'(mix_reg), 32'd0);
            check("gap_done", 32'(done), 32'd1);
            tick();
        end

        // start while busy is ignored
        start_op(2'b01, 4'b1011, 9'b000001011);
        start = 1'b1; op = 2'b00; q = 4'b0000;
        do_step(1'b1, 1'b1, 5'b00001, 1'b1);
        check("div_example", 32'(mix_reg), 32'b000110111);
        start = 1'b1; op = 2'b10;
        do_step(1'b1, 1'b0, 5'b0, 1'b0);
        do_step(1'b1, 1'b0, 5'b0, 1'b1);
        check("busy_start_cnt", 32'(step_cnt), 32'd3);
        do_step(1'b1, 1'b0, 5'b0, 1'b0);
        check("busy_start_done", 32'(done), 32'd1);
        tick();

        // clr in RUN
        start_op(2'b00, 4'b0101, 9'b000001010);
        do_step(1'b1, 1'b0, 5'b0, 1'b0);
        clr = 1'b1; step_en = 1'b1; start = 1'b1;
        tick();
        clr = 1'b0; step_en = 1'b0; start = 1'b0;
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_mix", 32'(mix_reg), 32'd0);
        check("clr_cnt", 32'(step_cnt), 32'd0);
        check("clr_state", 32'(state_dbg), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("clr_no_done", 32'(done), 32'd0);
            tick();
        end

        // async reset after two DIV steps
        start_op(2'b01, 4'b1011, 9'b000001011);
        do_step(1'b1, 1'b0, 5'b0, 1'b1);
        do_step(1'b1, 1'b0, 5'b0, 1'b1);
        rst = 1'b0;
        #1;
        check("arst_mix", 32'(mix_reg), 32'd0);
        check("arst_cnt", 32'(step_cnt), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        #3;
        rst = 1'b1;
        tick();
        check("arst_after_done", 32'(done), 32'd0);
        check("arst_after_busy", 32'(busy), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
